// File: rtl/cpu_bus_responder_pkg.sv
// Shared encodings and widths for the CPU bus responder: FSM states,
// channel selects and the instruction/data/address widths.
package cpu_bus_responder_pkg;

  localparam int INST_W = 18;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_INST = 2'd1,
    CH_DATA = 2'd2,
    CH_PORT = 2'd3
  } chan_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Down-counter that paces the WAIT state: loaded at request acceptance,
// decremented each wait cycle, done on its last wait cycle.
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       count,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt <= 4'd1);

endmodule

// File: rtl/cpu_bus_responder.sv
// Three-channel bus responder (instruction fetch, data memory, I/O ports)
// with fixed-priority arbitration and a configurable number of wait states.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int PORT_COUNT  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_stb_i,
  input  logic [ADDR_W-1:0] inst_adr_i,
  output logic [INST_W-1:0] inst_dat_o,
  output logic              inst_ack_o,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [DATA_W-1:0] data_dat_i,
  output logic [DATA_W-1:0] data_dat_o,
  output logic              data_ack_o,
  input  logic              port_stb_i,
  input  logic              port_we_i,
  input  logic [ADDR_W-1:0] port_adr_i,
  input  logic [DATA_W-1:0] port_dat_i,
  output logic [DATA_W-1:0] port_dat_o,
  output logic              port_ack_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_adr_i,
  input  logic [INST_W-1:0] prog_dat_i,
  output logic [1:0]        state_o
);

  logic [INST_W-1:0] imem [256];
  logic [DATA_W-1:0] dmem [256];
  logic [DATA_W-1:0] port_reg [PORT_COUNT];

  state_t            state_q, state_d;
  chan_t             sel_q, win;
  logic [ADDR_W-1:0] adr_q, win_adr, rd_adr;
  logic [DATA_W-1:0] wdat_q, win_dat, port_rd;
  logic              we_q, win_we;
  logic              take, load, count, done, sel_stb;
  logic              enter_ack, commit_data, commit_port;
  chan_t             rd_sel;

  bus_wait_counter u_wait (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .load_val (4'(WAIT_STATES)),
    .count    (count),
    .done     (done)
  );

  // Fixed priority: inst > data > port
  always_comb begin
    win     = CH_NONE;
    win_adr = '0;
    win_dat = '0;
    win_we  = 1'b0;
    if (inst_stb_i) begin
      win     = CH_INST;
      win_adr = inst_adr_i;
    end else if (data_stb_i) begin
      win     = CH_DATA;
      win_adr = data_adr_i;
      win_dat = data_dat_i;
      win_we  = data_we_i;
    end else if (port_stb_i) begin
      win     = CH_PORT;
      win_adr = port_adr_i;
      win_dat = port_dat_i;
      win_we  = port_we_i;
    end
  end

  always_comb begin
    case (sel_q)
      CH_INST: sel_stb = inst_stb_i;
      CH_DATA: sel_stb = data_stb_i;
      CH_PORT: sel_stb = port_stb_i;
      default: sel_stb = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    load    = 1'b0;
    count   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win != CH_NONE) begin
          take    = 1'b1;
          load    = 1'b1;
          state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!sel_stb) state_d = ST_IDLE;
        else if (done) state_d = ST_ACK;
        else count = 1'b1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is captured on the edge entering ACK; with zero wait states that
  // is the acceptance edge itself, so the live request is used instead of the latch.
  assign enter_ack   = (state_d == ST_ACK);
  assign rd_sel      = take ? win : sel_q;
  assign rd_adr      = take ? win_adr : adr_q;
  assign port_rd     = (rd_adr < 8'(PORT_COUNT)) ? port_reg[rd_adr[3:0]] : '0;
  assign commit_data = (state_q == ST_ACK) && (sel_q == CH_DATA) && we_q && !rst_i;
  assign commit_port = (state_q == ST_ACK) && (sel_q == CH_PORT) && we_q
                       && (adr_q < 8'(PORT_COUNT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= CH_NONE;
      inst_ack_o <= 1'b0;
      data_ack_o <= 1'b0;
      port_ack_o <= 1'b0;
      inst_dat_o <= '0;
      data_dat_o <= '0;
      port_dat_o <= '0;
      for (int i = 0; i < PORT_COUNT; i++) port_reg[i] <= '0;
    end else begin
      state_q    <= state_d;
      if (take) sel_q <= win;
      inst_ack_o <= enter_ack && (rd_sel == CH_INST);
      data_ack_o <= enter_ack && (rd_sel == CH_DATA);
      port_ack_o <= enter_ack && (rd_sel == CH_PORT);
      if (enter_ack) begin
        case (rd_sel)
          CH_INST: inst_dat_o <= imem[rd_adr];
          CH_DATA: data_dat_o <= dmem[rd_adr];
          CH_PORT: port_dat_o <= port_rd;
          default: ;
        endcase
      end
      if (commit_port) port_reg[adr_q[3:0]] <= wdat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      adr_q  <= win_adr;
      wdat_q <= win_dat;
      we_q   <= win_we;
    end
  end

  // Memories are never cleared; program loading is independent of the FSM
  always_ff @(posedge clk_i) begin
    if (prog_we_i) imem[prog_adr_i] <= prog_dat_i;
    if (commit_data) dmem[adr_q] <= wdat_q;
  end

  assign state_o = state_q;

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, giving the idle cycles inserted between request acceptance and ack (legal 0..15).
REQ-002 SHALL have parameter PORT_COUNT, default 16, giving the number of port registers (legal 1..16).
REQ-003 SHALL have port clk_i, in, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst_i, in, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have ports inst_stb_i in 1, inst_adr_i in 8, inst_dat_o out 18 and inst_ack_o out 1, forming the instruction-fetch read channel.
REQ-006 SHALL have ports data_stb_i in 1, data_we_i in 1, data_adr_i in 8, data_dat_i in 8, data_dat_o out 8 and data_ack_o out 1, forming the data-memory channel.
REQ-007 SHALL have ports port_stb_i in 1, port_we_i in 1, port_adr_i in 8, port_dat_i in 8, port_dat_o out 8 and port_ack_o out 1, forming the I/O-port channel.
REQ-008 SHALL have ports prog_we_i in 1, prog_adr_i in 8 and prog_dat_i in 18, used for program loading into instruction memory.
REQ-009 SHALL have port state_o, out, 2, exposing the current FSM state for debug.

Function
REQ-010 SHALL contain a 256x18 instruction memory, a 256x8 data memory and PORT_COUNT 8-bit port registers.
REQ-011 SHALL implement an FSM with states IDLE=0, WAIT=1 and ACK=2, plus a 4-bit wait counter.
REQ-012 In IDLE with any stb high, SHALL latch the winning channel, address, we and write data, then go to WAIT if WAIT_STATES>0, otherwise to ACK.
REQ-013 Arbitration SHALL use fixed priority inst > data > port; losers stay pending, unacked.
REQ-014 WAIT SHALL count WAIT_STATES cycles, then go to ACK; a request accepted at edge N SHALL therefore be acked during cycle N+1+WAIT_STATES.
REQ-015 ACK SHALL assert exactly the selected channel's ack for exactly one cycle, then return to IDLE.
REQ-016 A stb still high in the cycle after ack SHALL be treated as a new request.
REQ-017 Read data SHALL be registered and valid only in the ack cycle; outside that cycle it SHALL hold its last value.
REQ-018 Writes SHALL commit at the clock edge ending the ack cycle.
REQ-019 Port reads at addresses >= PORT_COUNT SHALL return 8'h00, and port writes at those addresses SHALL be ignored but still acked.
REQ-020 If the latched channel's stb drops during WAIT, the transaction SHALL be aborted: return to IDLE, no ack, no write.
REQ-021 inst_dat_o SHALL reflect the instruction memory contents at the ack cycle, including any prog write committed earlier.
REQ-022 prog_we_i SHALL write instruction memory in any state; when it targets the address being fetched in the same cycle, the old word SHALL be returned.
REQ-023 At most one ack SHALL be high in any cycle.

Reset
REQ-024 While rst_i is high at an edge, state SHALL go to IDLE, the counter to 0, all acks to 0, all dat_o outputs to 0 and all port registers to 0.
REQ-025 Memory arrays SHALL NOT be cleared by reset.
REQ-026 Reset during WAIT or ACK SHALL abort the transaction: no write performed, no ack in the following cycle.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/WAIT/ACK), the channel-select encoding, and the width constants 18 (instruction) and 8 (data/address).
REQ-028 A single sub-module, bus_wait_counter (load, count, done), is natural; the memories SHALL stay inline.

Verification
REQ-029 Scenario: WAIT_STATES=1, prog-load 0x10 with 18'b111000011001101000, then fetch 0x10 -> inst_ack_o pulses one cycle, 2 cycles after acceptance, with that word on inst_dat_o.
REQ-030 Scenario: data write 0x3C=0xA5, then read 0x3C -> each access acked once and the read returns 0xA5; with WAIT_STATES=0 the ack comes 1 cycle after acceptance.
REQ-031 Scenario: inst, data and port stb raised in the same cycle -> acks arrive in order inst, data, port, never overlapping.
REQ-032 Scenario: port write 0x20 with PORT_COUNT=16 -> acked, and a read of 0x20 returns 0x00; port write 0x05=0x7E then read 0x05 -> returns 0x7E.
REQ-033 Scenario: data write to 0x01 with stb dropped in WAIT (WAIT_STATES=3) -> no ack, and a later read of 0x01 returns the old value.
REQ-034 Scenario: rst_i pulsed during WAIT of a port write -> state_o=0 next cycle, no ack, and the port register stays 0.
